// File: rtl/counter_ctrl_pkg.sv
// Shared opcode and state encodings for the LED counter run controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// Modulo-PRESCALE tick generator that paces free-run increments.
// Only instantiated when PRESCALER_EN is defined.
module counter_ctrl_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    // The tick fires on the last phase of each period, so the first tick
    // after a clear lands PRESCALE enabled cycles later.
    assign tick = enable && (phase == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= tick ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/counter_run_controller.sv
// Run/step/stop/load sequencer owning the LED counter register.
// Optional free-run prescaler enabled by defining PRESCALER_EN.
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 7,
    parameter int PRESCALE = 4
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             busy_q;
    logic             accept;
    logic             run_tick;
    logic             at_terminal;
    logic [WIDTH-1:0] inc_value;
    logic [WIDTH-1:0] load_value;
    op_t              op;

    // Ready depends only on registered state, gated low while reset is held.
    assign cmd_ready   = !input_reset1_2 && (state_q != ST_STEP);
    assign accept      = cmd_valid && cmd_ready;
    assign op          = op_t'(cmd_op);
    assign at_terminal = (count_q == TERM);
    assign inc_value   = at_terminal ? '0 : count_q + 1'b1;
    assign load_value  = (cmd_data > TERM) ? TERM : cmd_data;

`ifdef PRESCALER_EN
    logic presc_clear;

    // Restart the period on RUN entry and on every accepted load.
    assign presc_clear = input_reset1_2
                       || (accept && op == OP_LOAD)
                       || (accept && op == OP_RUN && state_q == ST_IDLE);

    counter_ctrl_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (input_clock1_1),
        .clear  (presc_clear),
        .enable (state_q == ST_RUN),
        .tick   (run_tick)
    );
`else
    logic unused_prescale;

    // Without the prescaler RUN advances every cycle and PRESCALE is inert.
    assign unused_prescale = (PRESCALE >= 1);
    assign run_tick        = 1'b1;
`endif

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_RUN: begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                            end
                            OP_STEP: begin
                                state_q <= ST_STEP;
                                busy_q  <= 1'b1;
                            end
                            OP_LOAD: count_q <= load_value;
                            default: ;
                        endcase
                    end
                end
                // STOP freezes immediately and a load beats a due increment.
                ST_RUN: begin
                    if (accept && op == OP_STOP) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (accept && op == OP_LOAD) begin
                        count_q <= load_value;
                    end else if (run_tick) begin
                        count_q <= inc_value;
                        wrap_q  <= at_terminal;
                    end
                end
                ST_STEP: begin
                    count_q <= inc_value;
                    wrap_q  <= at_terminal;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule
